tag_store: RTL and testbench

TAG_STORE -- requirements
Module: tag_store

---
 rtl/tag_store_pkg.sv | 18 +
 rtl/tag_entry.sv | 33 +++
 rtl/tag_store_entry.sv | 1 +
 rtl/tag_store.sv | 125 ++++++++++++
 tb/tb_tag_store.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/tag_store_pkg.sv
// Shared types and width helpers for the set-associative tag store.
package tag_store_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic int set_w(input int sets);
        return $clog2(sets);
    endfunction

    // A direct-mapped store still carries a 1-bit way index.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/tag_entry.sv
// One tag register plus valid bit, with clear, fill/invalidate write and tag compare.
module tag_entry #(
    parameter int TAG_W = 26
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic             inval_i,
    input  logic [TAG_W-1:0] wtag_i,
    input  logic [TAG_W-1:0] ctag_i,
    output logic             match_o
);

    logic [TAG_W-1:0] tag_q;
    logic             valid_q;

    // Sweep clear outranks a write; invalidation keeps the old tag.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if (we_i) begin
            tag_q   <= inval_i ? tag_q : wtag_i;
            valid_q <= !inval_i;
        end else begin
            tag_q   <= tag_q;
            valid_q <= valid_q;
        end
    end

    assign match_o = valid_q && (tag_q == ctag_i);

endmodule

// File: rtl/tag_store_entry.sv
// Per-way tag and valid storage is implemented by module tag_entry in rtl/tag_entry.sv.

// File: rtl/tag_store.sv
// Set-associative tag store: clear sweep FSM, fill/invalidate writes, 1-cycle lookup.
module tag_store
    import tag_store_pkg::*;
#(
    parameter int TAG_W = 26,
    parameter int SETS  = 16,
    parameter int WAYS  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lookup_valid,
    output logic                      lookup_ready,
    input  logic [set_w(SETS)-1:0]    lookup_set,
    input  logic [TAG_W-1:0]          lookup_tag,
    output logic                      hit_valid,
    output logic                      hit,
    output logic [way_w(WAYS)-1:0]    hit_way,
    input  logic                      write_en,
    input  logic [set_w(SETS)-1:0]    write_set,
    input  logic [way_w(WAYS)-1:0]    write_way,
    input  logic [TAG_W-1:0]          write_tag,
    input  logic                      write_inval,
    input  logic                      inv_all,
    output logic                      busy
);

    localparam int SET_W = set_w(SETS);
    localparam int WAY_W = way_w(WAYS);

    state_e           state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic             hit_valid_q, hit_valid_d;
    logic             hit_q, hit_d;
    logic [WAY_W-1:0] hit_way_q, hit_way_d;

    logic             match_s [SETS][WAYS];
    logic             wr_ok_s;
    logic             accept_s;
    logic             hit_any_s;
    logic [WAY_W-1:0] hit_idx_s;

    assign wr_ok_s  = write_en && (state_q == RUN) && !inv_all;
    assign accept_s = lookup_valid && (state_q == RUN);

    for (genvar s = 0; s < SETS; s++) begin : g_set
        for (genvar w = 0; w < WAYS; w++) begin : g_way
            tag_entry #(.TAG_W(TAG_W)) u_entry (
                .clk     (clk),
                .clr_i   ((state_q == CLEAR) && (cnt_q == SET_W'(s))),
                .we_i    (wr_ok_s && (write_set == SET_W'(s)) && (write_way == WAY_W'(w))),
                .inval_i (write_inval),
                .wtag_i  (write_tag),
                .ctag_i  (lookup_tag),
                .match_o (match_s[s][w])
            );
        end
    end

    // Lowest matching way wins: scan downward so the last assignment is the smallest index.
    always_comb begin
        hit_any_s = 1'b0;
        hit_idx_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_any_s = hit_any_s | match_s[lookup_set][w];
            hit_idx_s = match_s[lookup_set][w] ? WAY_W'(w) : hit_idx_s;
        end
    end

    // Sweep FSM next state and lookup result pipeline.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hit_valid_d = accept_s;
        hit_d       = accept_s ? hit_any_s : hit_q;
        hit_way_d   = accept_s ? hit_idx_s : hit_way_q;
        case (state_q)
            CLEAR: begin
                if (inv_all) begin
                    cnt_d = '0;
                end else if (cnt_q == SET_W'(SETS - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SET_W'(1);
                end
            end
            RUN: begin
                if (inv_all) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State and result registers; reset forces a fresh sweep and drops any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_way_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hit_valid_q <= hit_valid_d;
            hit_q       <= hit_d;
            hit_way_q   <= hit_way_d;
        end
    end

    assign lookup_ready = (state_q == RUN);
    assign busy         = (state_q == CLEAR);
    assign hit_valid    = hit_valid_q;
    assign hit          = hit_q;
    assign hit_way      = hit_way_q;

endmodule

// File: tb/tb_tag_store.sv
// Directed vector bench for tag_store with default parameters (TAG_W=26, SETS=16, WAYS=4).
module tb_tag_store;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic        lookup_ready;
    logic [3:0]  lookup_set;
    logic [25:0] lookup_tag;
    logic        hit_valid;
    logic        hit;
    logic [1:0]  hit_way;
    logic        write_en;
    logic [3:0]  write_set;
    logic [1:0]  write_way;
    logic [25:0] write_tag;
    logic        write_inval;
    logic        inv_all;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wen;
        logic        winv;
        logic [3:0]  wset;
        logic [1:0]  wway;
        logic [25:0] wtag;
        logic        lv;
        logic [3:0]  lset;
        logic [25:0] ltag;
        logic        ehv;
        logic        ehit;
        logic [1:0]  eway;
    } vec_t;

    vec_t vecs [17];

    tag_store dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .lookup_set   (lookup_set),
        .lookup_tag   (lookup_tag),
        .hit_valid    (hit_valid),
        .hit          (hit),
        .hit_way      (hit_way),
        .write_en     (write_en),
        .write_set    (write_set),
        .write_way    (write_way),
        .write_tag    (write_tag),
        .write_inval  (write_inval),
        .inv_all      (inv_all),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        lookup_valid = 1'b0; lookup_set = 4'd0; lookup_tag = 26'd0;
        write_en = 1'b0; write_set = 4'd0; write_way = 2'd0; write_tag = 26'd0;
        write_inval = 1'b0; inv_all = 1'b0;
    endtask

    // Counts cycles until lookup_ready; hit_valid must stay low meanwhile.
    task automatic wait_sweep(input string name, output int n);
        n = 0;
        while (!lookup_ready && n < 40) begin
            chk({name, "_hv_low"}, {31'd0, hit_valid}, 32'd0);
            tick();
            n++;
        end
    endtask

    task automatic lookup(input string name, input logic [3:0] s, input logic [25:0] t,
                          input logic ehit, input logic [1:0] eway);
        lookup_valid = 1'b1; lookup_set = s; lookup_tag = t;
        tick();
        lookup_valid = 1'b0;
        chk({name, "_hv"},  {31'd0, hit_valid}, 32'd1);
        chk({name, "_hit"}, {31'd0, hit}, {31'd0, ehit});
        chk({name, "_way"}, {30'd0, hit_way}, {30'd0, eway});
    endtask

    initial begin
        int n;
        //            wen  winv  wset   wway  wtag           lv    lset   ltag           ehv   ehit  eway
        vecs[0]  = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b1, 4'd3, 26'h0,       1'b1, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 4'd5, 2'd2, 26'h2ABCDEF, 1'b0, 4'd0, 26'h0,       1'b0, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b1, 4'd5, 26'h2ABCDEF, 1'b1, 1'b1, 2'd2};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b1, 4'd6, 26'h2ABCDEF, 1'b1, 1'b0, 2'd0};
        vecs[4]  = '{1'b1, 1'b0, 4'd1, 2'd0, 26'h123,     1'b1, 4'd1, 26'h123,     1'b1, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b1, 4'd1, 26'h123,     1'b1, 1'b1, 2'd0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b0, 4'd0, 26'h0,       1'b0, 1'b1, 2'd0};
        vecs[7]  = '{1'b1, 1'b0, 4'd7, 2'd3, 26'h55,      1'b0, 4'd0, 26'h0,       1'b0, 1'b1, 2'd0};
        vecs[8]  = '{1'b1, 1'b0, 4'd7, 2'd1, 26'h55,      1'b1, 4'd7, 26'h55,      1'b1, 1'b1, 2'd3};
        vecs[9]  = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b1, 4'd7, 26'h55,      1'b1, 1'b1, 2'd1};
        vecs[10] = '{1'b1, 1'b1, 4'd7, 2'd1, 26'h0,       1'b1, 4'd7, 26'h55,      1'b1, 1'b1, 2'd1};
        vecs[11] = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b1, 4'd7, 26'h55,      1'b1, 1'b1, 2'd3};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b1, 4'd5, 26'h0ABCDEF, 1'b1, 1'b0, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b1, 4'd5, 26'h2ABCDEF, 1'b1, 1'b1, 2'd2};
        vecs[14] = '{1'b1, 1'b1, 4'd5, 2'd2, 26'h0,       1'b0, 4'd0, 26'h0,       1'b0, 1'b1, 2'd2};
        vecs[15] = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b1, 4'd5, 26'h2ABCDEF, 1'b1, 1'b0, 2'd0};
        vecs[16] = '{1'b0, 1'b0, 4'd0, 2'd0, 26'h0,       1'b0, 4'd5, 26'h2ABCDEF, 1'b0, 1'b0, 2'd0};

        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy",  {31'd0, busy}, 32'd1);
        chk("rst_ready", {31'd0, lookup_ready}, 32'd0);
        chk("rst_hv",    {31'd0, hit_valid}, 32'd0);
        chk("rst_hit",   {31'd0, hit}, 32'd0);
        chk("rst_way",   {30'd0, hit_way}, 32'd0);
        wait_sweep("rst_sweep", n);
        chk("rst_sweep_len", n, 32'd16);
        chk("run_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            lookup_valid = vecs[i].lv;   lookup_set = vecs[i].lset; lookup_tag = vecs[i].ltag;
            write_en = vecs[i].wen;      write_inval = vecs[i].winv;
            write_set = vecs[i].wset;    write_way = vecs[i].wway;  write_tag = vecs[i].wtag;
            tick();
            $display("vector %0d", i);
            chk("vec_ready", {31'd0, lookup_ready}, 32'd1);
            chk("vec_hv",    {31'd0, hit_valid}, {31'd0, vecs[i].ehv});
            chk("vec_hit",   {31'd0, hit}, {31'd0, vecs[i].ehit});
            chk("vec_way",   {30'd0, hit_way}, {30'd0, vecs[i].eway});
        end
        idle();

        // Sweep restarted mid-way; a write held through the whole sweep must not land.
        write_en = 1'b1; write_set = 4'd4; write_way = 2'd0; write_tag = 26'h444;
        tick();
        idle();
        lookup("pre_inv", 4'd4, 26'h444, 1'b1, 2'd0);
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        write_en = 1'b1; write_set = 4'd2; write_way = 2'd1; write_tag = 26'h777;
        lookup_valid = 1'b1; lookup_set = 4'd2; lookup_tag = 26'h777;
        for (int i = 0; i < 8; i++) begin
            chk("sweep1_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        chk("restart_busy", {31'd0, busy}, 32'd1);
        wait_sweep("restart_sweep", n);
        chk("restart_sweep_len", n, 32'd16);
        idle();
        lookup("sweep_write_ignored", 4'd2, 26'h777, 1'b0, 2'd0);
        lookup("sweep_cleared", 4'd4, 26'h444, 1'b0, 2'd0);

        // Reset right behind an accepted lookup.
        write_en = 1'b1; write_set = 4'd10; write_way = 2'd3; write_tag = 26'hABC;
        tick();
        idle();
        lookup("pre_rst", 4'd10, 26'hABC, 1'b1, 2'd3);
        reset = 1'b1;
        lookup_valid = 1'b1; lookup_set = 4'd10; lookup_tag = 26'hABC;
        tick();
        reset = 1'b0;
        idle();
        chk("midrst_hv",   {31'd0, hit_valid}, 32'd0);
        chk("midrst_hit",  {31'd0, hit}, 32'd0);
        chk("midrst_way",  {30'd0, hit_way}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        wait_sweep("midrst_sweep", n);
        chk("midrst_sweep_len", n, 32'd16);
        lookup("post_rst_a", 4'd10, 26'hABC, 1'b0, 2'd0);
        lookup("post_rst_b", 4'd7, 26'h55, 1'b0, 2'd0);
        lookup("post_rst_c", 4'd1, 26'h123, 1'b0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
